i2c_slave_target: RTL and testbench

Synthesizable I2C target (slave) that answers the bus driven by the team's I2C master, giving the FIFO-based bridge a real RTL endpoint instead of a behavioural model. It oversamples SDA/SCL on a single system clock, detects START/STOP, matches a 7-bit address, and moves data bytes through FIFO-style strobes. For write transfers it pushes bytes into an RX FIFO. For read transfers it pops bytes from a TX FIFO.

---
 rtl/i2c_slave_target_if.sv | 33 +++
 rtl/i2c_slave_target.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_slave_target.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_target_if.sv
// FIFO-side handshake bundle for the I2C target: RX push strobe, TX pop strobe,
// FIFO status flags and the transfer-busy indication.
interface i2c_slave_target_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_full;
  logic [DATAWIDTH-1:0] tx_data;
  logic                 tx_rd_en;
  logic                 tx_empty;
  logic                 busy;

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_full,
    input  tx_data,
    output tx_rd_en,
    input  tx_empty,
    output busy
  );

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_full,
    output tx_data,
    input  tx_rd_en,
    output tx_empty,
    input  busy
  );
endinterface

// File: rtl/i2c_slave_target.sv
// Oversampling I2C target: synchronizes SCL/SDA, detects START/STOP, matches a
// 7-bit address and moves bytes between the bus and RX/TX FIFO strobes.
module i2c_slave_target #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned DATAWIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  i2c_slave_target_if.slave fifo
);

  localparam int unsigned    CW       = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(DATAWIDTH - 1);
  localparam logic [CW-1:0]  ALL_BITS = CW'(DATAWIDTH);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_e;

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_hist_q;
  logic       sda_hist_q;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise_d;
  logic       scl_fall_d;
  logic       start_d;
  logic       stop_d;

  state_e               state_q;
  logic [DATAWIDTH-1:0] shreg_q;
  logic [CW-1:0]        bitcnt_q;
  logic                 rw_q;
  logic                 sda_low_q;
  logic [DATAWIDTH-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 tx_rd_en_q;
  logic                 busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  // SDA edges only count as START/STOP when SCL was high on both samples.
  always_comb begin
    scl_rise_d = scl_s & ~scl_hist_q;
    scl_fall_d = ~scl_s & scl_hist_q;
    start_d    = sda_hist_q & ~sda_s & scl_s & scl_hist_q;
    stop_d     = ~sda_hist_q & sda_s & scl_s & scl_hist_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      rw_q       <= 1'b0;
      sda_low_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_rd_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_rd_en_q <= 1'b0;

      // TX FIFO data is valid the cycle after the pop strobe.
      if (tx_rd_en_q) begin
        shreg_q <= fifo.tx_data;
      end

      if (start_d) begin
        state_q   <= ADDR;
        bitcnt_q  <= '0;
        sda_low_q <= 1'b0;
        busy_q    <= 1'b0;
      end else if (stop_d) begin
        state_q   <= IDLE;
        sda_low_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise_d && (bitcnt_q != ALL_BITS)) begin
              shreg_q  <= {shreg_q[DATAWIDTH-2:0], sda_s};
              bitcnt_q <= bitcnt_q + 1'b1;
            end else if (scl_fall_d && (bitcnt_q == ALL_BITS)) begin
              bitcnt_q <= '0;
              if (shreg_q[DATAWIDTH-1:1] == SLAVE_ADDR) begin
                rw_q      <= shreg_q[0];
                sda_low_q <= 1'b1;
                busy_q    <= 1'b1;
                state_q   <= ADDR_ACK;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_rise_d && rw_q) begin
              if (!fifo.tx_empty) begin
                tx_rd_en_q <= 1'b1;
              end else begin
                shreg_q <= '1;
              end
            end else if (scl_fall_d) begin
              if (rw_q) begin
                sda_low_q <= ~shreg_q[DATAWIDTH-1];
                shreg_q   <= {shreg_q[DATAWIDTH-2:0], 1'b0};
                bitcnt_q  <= CW'(1);
                state_q   <= RD_DATA;
              end else begin
                sda_low_q <= 1'b0;
                bitcnt_q  <= '0;
                state_q   <= WR_DATA;
              end
            end
          end

          WR_DATA: begin
            if (scl_rise_d && (bitcnt_q != ALL_BITS)) begin
              shreg_q  <= {shreg_q[DATAWIDTH-2:0], sda_s};
              bitcnt_q <= bitcnt_q + 1'b1;
              if (bitcnt_q == LAST_BIT) begin
                if (fifo.rx_full) begin
                  state_q <= WAIT_STOP;
                end else begin
                  rx_data_q  <= {shreg_q[DATAWIDTH-2:0], sda_s};
                  rx_valid_q <= 1'b1;
                end
              end
            end else if (scl_fall_d && (bitcnt_q == ALL_BITS)) begin
              sda_low_q <= 1'b1;
              bitcnt_q  <= '0;
              state_q   <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (scl_fall_d) begin
              sda_low_q <= 1'b0;
              state_q   <= WR_DATA;
            end
          end

          // bitcnt_q counts bits already placed on SDA; the fall after the
          // last bit's clock hands the line back to the master for ACK.
          RD_DATA: begin
            if (scl_fall_d) begin
              if (bitcnt_q == ALL_BITS) begin
                sda_low_q <= 1'b0;
                bitcnt_q  <= '0;
                state_q   <= RD_ACK;
              end else begin
                sda_low_q <= ~shreg_q[DATAWIDTH-1];
                shreg_q   <= {shreg_q[DATAWIDTH-2:0], 1'b0};
                bitcnt_q  <= bitcnt_q + 1'b1;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise_d) begin
              if (!sda_s) begin
                if (!fifo.tx_empty) begin
                  tx_rd_en_q <= 1'b1;
                end else begin
                  shreg_q <= '1;
                end
                bitcnt_q <= '0;
                state_q  <= RD_DATA;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end

          WAIT_STOP: begin
            sda_low_q <= 1'b0;
          end

          default: begin
            sda_low_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2c_sda       = sda_low_q ? 1'b0 : 1'bz;
  assign fifo.rx_data  = rx_data_q;
  assign fifo.rx_valid = rx_valid_q;
  assign fifo.tx_rd_en = tx_rd_en_q;
  assign fifo.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bus-level bench for i2c_slave_target: a bit-banged I2C master, a show-ahead
// TX FIFO, strobe monitors and a queue-based model of the expected traffic.
module tb_i2c_slave_target;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_target_if #(.DATAWIDTH(8)) fifo_if ();

  i2c_slave_target #(.SLAVE_ADDR(7'h50), .DATAWIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .i2c_scl (scl),
    .i2c_sda (sda_bus),
    .fifo    (fifo_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Show-ahead TX FIFO; the pointer advances on the edge that ends tx_rd_en.
  logic [7:0]  tx_mem [0:63];
  int unsigned tx_wr = 0;
  int unsigned tx_rd = 0;
  logic [7:0]  tx_model[$];

  assign fifo_if.tx_data  = tx_mem[tx_rd[5:0]];
  assign fifo_if.tx_empty = (tx_rd == tx_wr);

  always @(posedge clk) begin
    if (fifo_if.tx_rd_en) tx_rd <= tx_rd + 1;
  end

  logic [7:0] rx_seen[$];
  int   n_rd = 0;
  int   n_both = 0;
  int   n_long = 0;
  int   n_dut_low = 0;
  logic prev_rxv = 1'b0;
  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    if (fifo_if.rx_valid) rx_seen.push_back(fifo_if.rx_data);
    if (fifo_if.tx_rd_en) n_rd++;
    if (fifo_if.rx_valid && fifo_if.tx_rd_en) n_both++;
    if ((fifo_if.rx_valid && prev_rxv) || (fifo_if.tx_rd_en && prev_rd)) n_long++;
    prev_rxv = fifo_if.rx_valid;
    prev_rd  = fifo_if.tx_rd_en;
    if (sda_bus === 1'b0 && !m_sda_low) n_dut_low++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_wr[5:0]] = b;
    tx_wr++;
    tx_model.push_back(b);
  endtask

  // One SCL period; the master wiggles SDA early in the low phase.
  task automatic bit_xfer(input logic b, output logic s);
    clk_wait(1);
    m_sda_low = 1'($urandom_range(0, 1));
    clk_wait(2);
    m_sda_low = ~b;
    clk_wait(7);
    scl = 1'b1;
    clk_wait(5);
    s = sda_bus;
    clk_wait(5);
    scl = 1'b0;
  endtask

  task automatic bus_start();
    if (!scl) begin
      clk_wait(3);
      m_sda_low = 1'b0;
      clk_wait(7);
      scl = 1'b1;
    end
    clk_wait(10);
    m_sda_low = 1'b1;
    clk_wait(10);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    clk_wait(3);
    m_sda_low = 1'b1;
    clk_wait(7);
    scl = 1'b1;
    clk_wait(10);
    m_sda_low = 1'b0;
    clk_wait(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, s);
      d = {d[6:0], s};
    end
    bit_xfer(~mack, s);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk_wait(4);
    checks++; if (fifo_if.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b want 0", fifo_if.rx_valid); end
    checks++; if (fifo_if.tx_rd_en !== 1'b0) begin failures++; $display("FAIL reset_tx_rd_en: got %b want 0", fifo_if.tx_rd_en); end
    checks++; if (fifo_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", fifo_if.busy); end
    checks++; if (fifo_if.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h want 00", fifo_if.rx_data); end
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b want 1", sda_bus); end
    reset = 1'b0;
    clk_wait(5);
  endtask

  task automatic test_write();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] data[$];
      logic       ack;
      int         rx0;
      int         n;
      if (it == 0) begin
        data.push_back(8'hA5);
        data.push_back(8'h3C);
      end else begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) data.push_back(8'($urandom));
      end
      rx0 = rx_seen.size();
      bus_start();
      send_byte({7'h50, 1'b0}, ack);
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_addr_ack it%0d: got %b want 1", it, ack); end
      checks++; if (fifo_if.busy !== 1'b1) begin failures++; $display("FAIL wr_busy it%0d: got %b want 1", it, fifo_if.busy); end
      for (int k = 0; k < data.size(); k++) begin
        send_byte(data[k], ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_data_ack it%0d b%0d: got %b want 1", it, k, ack); end
      end
      bus_stop();
      clk_wait(5);
      checks++; if (fifo_if.busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after_stop it%0d: got %b want 0", it, fifo_if.busy); end
      checks++; if (rx_seen.size() - rx0 != data.size()) begin failures++; $display("FAIL wr_rx_count it%0d: got %0d want %0d", it, rx_seen.size() - rx0, data.size()); end
      for (int k = 0; k < data.size() && rx0 + k < rx_seen.size(); k++) begin
        checks++; if (rx_seen[rx0 + k] !== data[k]) begin failures++; $display("FAIL wr_rx_data it%0d b%0d: got %h want %h", it, k, rx_seen[rx0 + k], data[k]); end
      end
    end
  endtask

  task automatic test_addr_mismatch();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] first;
      logic       ack;
      int         rx0;
      int         low0;
      if (it == 0) first = 8'hA2;
      else begin
        first = 8'($urandom);
        while (first[7:1] == 7'h50) first = 8'($urandom);
      end
      rx0  = rx_seen.size();
      low0 = n_dut_low;
      bus_start();
      send_byte(first, ack);
      checks++; if (ack !== 1'b0) begin failures++; $display("FAIL nm_addr_ack it%0d: got %b want 0", it, ack); end
      send_byte(8'h11, ack);
      checks++; if (ack !== 1'b0) begin failures++; $display("FAIL nm_data_ack it%0d: got %b want 0", it, ack); end
      checks++; if (fifo_if.busy !== 1'b0) begin failures++; $display("FAIL nm_busy it%0d: got %b want 0", it, fifo_if.busy); end
      bus_stop();
      clk_wait(5);
      checks++; if (n_dut_low != low0) begin failures++; $display("FAIL nm_sda_pulled it%0d: got %0d low cycles want 0", it, n_dut_low - low0); end
      checks++; if (rx_seen.size() != rx0) begin failures++; $display("FAIL nm_rx_valid it%0d: got %0d want 0", it, rx_seen.size() - rx0); end
    end
  endtask

  task automatic test_read();
    for (int it = 0; it < 4; it++) begin
      logic [7:0] exp_b[$];
      logic [7:0] d;
      logic       ack;
      int         n;
      int         np;
      int         exp_rd;
      int         rd0;
      exp_rd = 0;
      if (it == 0) begin
        push_tx(8'h96);
        push_tx(8'h0F);
        n = 2;
      end else begin
        n  = $urandom_range(1, 3);
        np = $urandom_range(0, n);
        for (int k = 0; k < np; k++) push_tx(8'($urandom));
      end
      for (int k = 0; k < n; k++) begin
        if (tx_model.size() > 0) begin
          exp_b.push_back(tx_model.pop_front());
          exp_rd++;
        end else begin
          exp_b.push_back(8'hFF);
        end
      end
      rd0 = n_rd;
      bus_start();
      send_byte({7'h50, 1'b1}, ack);
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rd_addr_ack it%0d: got %b want 1", it, ack); end
      for (int k = 0; k < n; k++) begin
        recv_byte(k != n - 1, d);
        checks++; if (d !== exp_b[k]) begin failures++; $display("FAIL rd_data it%0d b%0d: got %h want %h", it, k, d, exp_b[k]); end
      end
      recv_byte(1'b0, d);
      checks++; if (d !== 8'hFF) begin failures++; $display("FAIL rd_after_nack it%0d: got %h want ff", it, d); end
      checks++; if (n_rd - rd0 != exp_rd) begin failures++; $display("FAIL rd_pop_count it%0d: got %0d want %0d", it, n_rd - rd0, exp_rd); end
      bus_stop();
      clk_wait(5);
      checks++; if (fifo_if.busy !== 1'b0) begin failures++; $display("FAIL rd_busy_after_stop it%0d: got %b want 0", it, fifo_if.busy); end
    end
  endtask

  task automatic test_tx_empty();
    logic [7:0] d;
    logic       ack;
    int         rd0;
    rd0 = n_rd;
    bus_start();
    send_byte({7'h50, 1'b1}, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL empty_addr_ack: got %b want 1", ack); end
    recv_byte(1'b0, d);
    checks++; if (d !== 8'hFF) begin failures++; $display("FAIL empty_data: got %h want ff", d); end
    checks++; if (n_rd != rd0) begin failures++; $display("FAIL empty_pop: got %0d pops want 0", n_rd - rd0); end
    bus_stop();
    clk_wait(5);
  endtask

  task automatic test_rx_full();
    logic ack;
    int   rx0;
    rx0 = rx_seen.size();
    fifo_if.rx_full = 1'b1;
    bus_start();
    send_byte({7'h50, 1'b0}, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL full_addr_ack: got %b want 1", ack); end
    send_byte(8'h55, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL full_data_ack: got %b want 0", ack); end
    fifo_if.rx_full = 1'b0;
    send_byte(8'($urandom), ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL full_wait_stop_ack: got %b want 0", ack); end
    bus_stop();
    clk_wait(5);
    checks++; if (rx_seen.size() != rx0) begin failures++; $display("FAIL full_rx_valid: got %0d want 0", rx_seen.size() - rx0); end
  endtask

  task automatic test_repeated_start_reset();
    logic [7:0] d;
    logic [7:0] exp_b;
    logic       ack;
    int         rx0;
    int         rd0;
    push_tx(8'($urandom));
    exp_b = tx_model.pop_front();
    rx0 = rx_seen.size();
    rd0 = n_rd;
    bus_start();
    send_byte({7'h50, 1'b0}, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rs_wr_addr_ack: got %b want 1", ack); end
    send_byte(8'h77, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rs_wr_data_ack: got %b want 1", ack); end
    bus_start();
    checks++; if (fifo_if.busy !== 1'b0) begin failures++; $display("FAIL rs_busy_cleared: got %b want 0", fifo_if.busy); end
    send_byte({7'h50, 1'b1}, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rs_rd_addr_ack: got %b want 1", ack); end
    recv_byte(1'b0, d);
    checks++; if (d !== exp_b) begin failures++; $display("FAIL rs_rd_data: got %h want %h", d, exp_b); end
    checks++; if (n_rd - rd0 != 1) begin failures++; $display("FAIL rs_pop_count: got %0d want 1", n_rd - rd0); end
    checks++; if (rx_seen.size() - rx0 != 1 || rx_seen[rx_seen.size() - 1] !== 8'h77) begin failures++; $display("FAIL rs_rx: got count %0d want 1 of 77", rx_seen.size() - rx0); end
    bus_stop();
    clk_wait(5);

    push_tx(8'h00);
    void'(tx_model.pop_front());
    bus_start();
    send_byte({7'h50, 1'b1}, ack);
    clk_wait(6);
    checks++; if (sda_bus !== 1'b0) begin failures++; $display("FAIL rst_pre_sda: got %b want 0 (target driving MSB)", sda_bus); end
    reset = 1'b1;
    clk_wait(1);
    checks++; if (sda_bus !== 1'b1) begin failures++; $display("FAIL rst_sda_release: got %b want 1", sda_bus); end
    checks++; if (fifo_if.rx_data !== 8'h00) begin failures++; $display("FAIL rst_rx_data: got %h want 00", fifo_if.rx_data); end
    checks++; if (fifo_if.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", fifo_if.busy); end
    checks++; if (fifo_if.rx_valid !== 1'b0 || fifo_if.tx_rd_en !== 1'b0) begin failures++; $display("FAIL rst_strobes: got rx_valid=%b tx_rd_en=%b want 0 0", fifo_if.rx_valid, fifo_if.tx_rd_en); end
    reset = 1'b0;
    clk_wait(3);
    scl = 1'b1;
    clk_wait(20);
  endtask

  task automatic test_strobes();
    checks++; if (n_both != 0) begin failures++; $display("FAIL strobe_overlap: got %0d cycles want 0", n_both); end
    checks++; if (n_long != 0) begin failures++; $display("FAIL strobe_width: got %0d multi-cycle pulses want 0", n_long); end
  endtask

  initial begin
    fifo_if.rx_full = 1'b0;
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_tx_empty();
    test_rx_full();
    test_repeated_start_reset();
    test_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
